// File: rtl/rv64_inst_fetcher.sv
// rv64_inst_fetcher
//   Instruction-supply side of the 32-bit instruction interface. Fetches bytes
//   from a byte-wide memory with a one-cycle read latency, packs them
//   little-endian into 32-bit words, and queues {word, pc} in a small FIFO
//   that is drained through a valid/ready handshake. A redirect flushes all
//   buffered and in-flight data and restarts fetch at the new PC. A
//   misaligned redirect parks the fetcher in an error state with a sticky
//   error flag.
//
// Parameters
//   RESET_PC    first fetch address after reset (word aligned)
//   FIFO_DEPTH  instruction FIFO entries, power of two, >= 2
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   o_mem_rd_en/addr      byte read request to memory
//   i_mem_rd_data         read byte, valid the cycle after o_mem_rd_en
//   o_inst_valid/i_inst_ready, o_inst_data, o_inst_pc   instruction output
//   i_redirect_valid/pc   restart fetch at a new PC
//   o_fetch_error         sticky misaligned-fetch flag
//
// Optional build macro INST_FETCH_PERF_EN adds:
//   o_perf_inst_cnt   handshakes taken (saturating)
//   o_perf_stall_cnt  cycles with ready high and no instruction (saturating)

module rv64_inst_fetcher #(
   parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic        o_mem_rd_en,
   output logic [63:0] o_mem_rd_addr,
   input  logic [7:0]  i_mem_rd_data,
   output logic        o_inst_valid,
   input  logic        i_inst_ready,
   output logic [31:0] o_inst_data,
   output logic [63:0] o_inst_pc,
   input  logic        i_redirect_valid,
   input  logic [63:0] i_redirect_pc,
   output logic        o_fetch_error
`ifdef INST_FETCH_PERF_EN
   ,
   output logic [63:0] o_perf_inst_cnt,
   output logic [63:0] o_perf_stall_cnt
`endif
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {ST_FETCH, ST_HOLD, ST_ERROR} state_t;

   state_t        r_state, w_state_nxt;
   logic [63:0]   r_fetch_pc, w_fetch_pc_nxt;
   logic [1:0]    r_byte_cnt, w_byte_cnt_nxt;
   logic          w_issue;          // a byte request goes out next cycle
   logic [63:0]   w_issue_addr;
   logic          w_start;          // that request is byte 0 of a new word
   logic          w_set_err;

   logic          r_mem_rd_en;
   logic [63:0]   r_mem_rd_addr;
   logic          r_d_vld;          // i_mem_rd_data carries a wanted byte
   logic [63:0]   r_d_addr;         // address that byte was read from
   logic [23:0]   r_word;           // bytes 0..2 of the word being assembled
   logic [CW-1:0] r_inflight;       // words started but not yet pushed
   logic          r_err;

   logic [31:0]   r_fifo_data [FIFO_DEPTH];
   logic [63:0]   r_fifo_pc   [FIFO_DEPTH];
   logic [PW-1:0] r_wr_ptr, r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_push, w_pop, w_space, w_valid;

   assign w_valid = (r_count != '0);
   // A redirect in the same cycle wins over both push and pop.
   assign w_push  = r_d_vld && (r_d_addr[1:0] == 2'd3) && !i_redirect_valid;
   assign w_pop   = w_valid && i_inst_ready && !i_redirect_valid;
   // Words already requested must have a guaranteed FIFO slot, so a new word
   // starts only if buffered + in-flight words leave room for it.
   assign w_space = ({1'b0, r_count} + {1'b0, r_inflight}) < (CW+1)'(FIFO_DEPTH);

   //---------------------------------------------------------------- next state
   always_comb begin
      w_state_nxt    = r_state;
      w_fetch_pc_nxt = r_fetch_pc;
      w_byte_cnt_nxt = r_byte_cnt;
      w_issue        = 1'b0;
      w_issue_addr   = r_fetch_pc + {62'd0, r_byte_cnt};
      w_start        = 1'b0;
      w_set_err      = 1'b0;
      if (i_redirect_valid) begin
         w_fetch_pc_nxt = i_redirect_pc;
         w_byte_cnt_nxt = 2'd0;
         if (i_redirect_pc[1:0] != 2'b00) begin
            w_state_nxt = ST_ERROR;
            w_set_err   = 1'b1;
         end else begin
            // The flush empties everything, so byte 0 of the target issues
            // straight away.
            w_state_nxt    = ST_FETCH;
            w_issue        = 1'b1;
            w_start        = 1'b1;
            w_issue_addr   = i_redirect_pc;
            w_byte_cnt_nxt = 2'd1;
         end
      end else begin
         case (r_state)
            ST_FETCH, ST_HOLD: begin
               if (r_byte_cnt != 2'd0 || w_space) begin
                  w_state_nxt    = ST_FETCH;
                  w_issue        = 1'b1;
                  w_start        = (r_byte_cnt == 2'd0);
                  w_byte_cnt_nxt = r_byte_cnt + 2'd1;
                  if (r_byte_cnt == 2'd3)
                     w_fetch_pc_nxt = r_fetch_pc + 64'd4;
               end else begin
                  w_state_nxt = ST_HOLD;
               end
            end
            default: ; // ST_ERROR: wait for an aligned redirect or reset
         endcase
      end
   end

   //------------------------------------------------------- fetch / assembly
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= ST_FETCH;
         r_fetch_pc    <= RESET_PC;
         r_byte_cnt    <= 2'd0;
         r_mem_rd_en   <= 1'b0;
         r_mem_rd_addr <= 64'd0;
         r_d_vld       <= 1'b0;
         r_d_addr      <= 64'd0;
         r_word        <= 24'd0;
         r_inflight    <= '0;
         r_err         <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_fetch_pc  <= w_fetch_pc_nxt;
         r_byte_cnt  <= w_byte_cnt_nxt;
         r_mem_rd_en <= w_issue;
         if (w_issue)
            r_mem_rd_addr <= w_issue_addr;
         // A request on the bus during a redirect returns a stale byte next
         // cycle; drop it here.
         r_d_vld  <= r_mem_rd_en && !i_redirect_valid;
         r_d_addr <= r_mem_rd_addr;
         if (r_d_vld) begin
            case (r_d_addr[1:0])
               2'd0:    r_word[7:0]   <= i_mem_rd_data;
               2'd1:    r_word[15:8]  <= i_mem_rd_data;
               2'd2:    r_word[23:16] <= i_mem_rd_data;
               default: ; // byte 3 is pushed directly with r_word
            endcase
         end
         if (i_redirect_valid)
            r_inflight <= CW'(w_start);
         else
            r_inflight <= r_inflight + CW'(w_start) - CW'(w_push);
         r_err <= r_err | w_set_err;
      end
   end

   //-------------------------------------------------------------------- FIFO
   always_ff @(posedge i_clk) begin
      if (i_rst || i_redirect_valid) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_fifo_data[r_wr_ptr] <= {i_mem_rd_data, r_word};
         r_fifo_pc[r_wr_ptr]   <= {r_d_addr[63:2], 2'b00};
      end
   end

   assign o_mem_rd_en   = r_mem_rd_en;
   assign o_mem_rd_addr = r_mem_rd_addr;
   assign o_inst_valid  = w_valid;
   // Zero the head when empty so reset and idle present clean values.
   assign o_inst_data   = w_valid ? r_fifo_data[r_rd_ptr] : 32'd0;
   assign o_inst_pc     = w_valid ? r_fifo_pc[r_rd_ptr]   : 64'd0;
   assign o_fetch_error = r_err;

`ifdef INST_FETCH_PERF_EN
   logic [63:0] r_perf_inst, r_perf_stall;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_perf_inst  <= 64'd0;
         r_perf_stall <= 64'd0;
      end else begin
         if (w_valid && i_inst_ready && r_perf_inst != '1)
            r_perf_inst <= r_perf_inst + 64'd1;
         if (!w_valid && i_inst_ready && r_perf_stall != '1)
            r_perf_stall <= r_perf_stall + 64'd1;
      end
   end

   assign o_perf_inst_cnt  = r_perf_inst;
   assign o_perf_stall_cnt = r_perf_stall;
`endif

endmodule
